sat_add_arbiter: RTL
====================

SAT_ADD_ARBITER -- requirements
Module: sat_add_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning operand and result width in bits (two's complement).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the saturation event counter width.
REQ-003 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1, synchronous active-high reset.
REQ-005 Port req0_valid, input, 1, requester 0 presents an operand pair.
REQ-006 Port req0_a, req0_b, input, WIDTH each, requester 0 signed operands.
REQ-007 Port req0_ready, output, 1, requester 0 pair accepted this cycle when high with req0_valid.
REQ-008 Ports req1_valid, req1_a, req1_b, req1_ready SHALL mirror REQ-005..007 for requester 1.
REQ-009 Port res_valid, output, 1, result register holds an unconsumed result.
REQ-010 Port res_ready, input, 1, consumer accepts the result this cycle.
REQ-011 Port res_sum, output, WIDTH, saturated signed sum.
REQ-012 Port res_id, output, 1, index of the requester that produced res_sum.
REQ-013 Port res_sat, output, 1, high when res_sum was clamped.
REQ-014 Port sat_count, output, CNT_W, number of clamped results accepted since reset.

Function
REQ-015 One shared saturating adder SHALL serve both requesters; at most one pair is accepted per cycle.
REQ-016 Saturation: both operands non-negative and raw WIDTH-bit sum negative -> max positive (0111 for WIDTH=4); both negative and raw sum non-negative -> min negative (1000); otherwise the raw wrapped sum.
REQ-017 Output state machine SHALL have two states: EMPTY (res_valid=0) and FULL (res_valid=1).
REQ-018 Slot free condition: state EMPTY, or state FULL with res_ready=1 (same-cycle drain and refill allowed).
REQ-019 Grant: only one requester valid -> that one; both valid -> the one not granted last (round-robin pointer last_id); none -> no grant.
REQ-020 reqN_ready SHALL be high only when requester N is granted and the slot is free; ready SHALL be low for a non-granted requester.
REQ-021 On acceptance, res_sum/res_id/res_sat SHALL load at that edge and res_valid SHALL be 1 the next cycle (latency 1); last_id SHALL update to the accepted index.
REQ-022 FULL with res_ready=0: res_sum, res_id, res_sat SHALL hold stable; no request accepted.
REQ-023 FULL with res_ready=1 and no grant: transition to EMPTY.
REQ-024 sat_count SHALL increment when a result with res_sat=1 is loaded, and SHALL stick at all-ones instead of wrapping.
REQ-025 Requester inputs changing while not accepted SHALL have no effect on state.

Reset
REQ-026 While rst=1 at a clock edge: res_valid=0, res_sum=0, res_id=0, res_sat=0, sat_count=0, last_id=1 (requester 0 wins first tie).
REQ-027 Reset mid-transaction SHALL discard the held result; ready outputs SHALL be low during the reset cycle.

Structure
REQ-028 Package sat_add_pkg SHALL hold WIDTH default, the max/min saturation constants derived from WIDTH, and the requester id type.
REQ-029 Saturating addition SHALL be a combinational sub-module sat_adder (a, b -> sum, sat), instantiated once.

Verification
REQ-030 Reset then req0 only, a=3, b=2, res_ready=1 -> req0_ready=1, next cycle res_valid=1, res_sum=5, res_id=0, res_sat=0.
REQ-031 Both valid every cycle, res_ready=1, req0 (4,7), req1 (-4,-7) -> grants alternate 0,1,0,...; results 7 sat=1, -8 sat=1; sat_count increments by 1 per result.
REQ-032 Result pending, res_ready=0 for 3 cycles with req1 (-1,2) valid -> req1_ready=0, res_sum stable; on res_ready=1 same-cycle refill -> next result 1, res_id=1.
REQ-033 Mixed-sign (7,-4) and (-7,4) -> 3 and -3, res_sat=0, sat_count unchanged.
REQ-034 Force 256 saturating results with CNT_W=8 -> sat_count holds 255.
REQ-035 Assert rst while FULL -> next cycle res_valid=0, sat_count=0, first tie after reset goes to requester 0.

Source files
------------

// File: rtl/sat_add_pkg.sv
// sat_add_pkg: shared widths, saturation limits and id/state types for the arbitrated saturating adder
package sat_add_pkg;
  localparam int DEF_WIDTH = 4;
  localparam logic [DEF_WIDTH-1:0] SAT_MAX = {1'b0, {(DEF_WIDTH-1){1'b1}}};
  localparam logic [DEF_WIDTH-1:0] SAT_MIN = {1'b1, {(DEF_WIDTH-1){1'b0}}};
  typedef enum logic {REQ0 = 1'b0, REQ1 = 1'b1} req_id_t;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
endpackage

// File: rtl/sat_add_arbiter_sat_adder.sv
// sat_adder: combinational two's-complement adder clamping to max/min on overflow
module sat_adder #(
  parameter int WIDTH = sat_add_pkg::DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             sat
);
  localparam logic [WIDTH-1:0] MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  logic [WIDTH-1:0] raw;
  logic ovf_pos, ovf_neg;
  always_comb begin
    raw     = a + b;
    ovf_pos = !a[WIDTH-1] && !b[WIDTH-1] && raw[WIDTH-1];
    ovf_neg = a[WIDTH-1] && b[WIDTH-1] && !raw[WIDTH-1];
    sum     = ovf_pos ? MAX : ovf_neg ? MIN : raw;
    sat     = ovf_pos || ovf_neg;
  end
endmodule

// File: rtl/sat_add_arbiter.sv
// sat_add_arbiter: round-robin arbitration of two requesters onto one saturating adder with a one-entry result slot
module sat_add_arbiter
  import sat_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_id,
  output logic             res_sat,
  output logic [CNT_W-1:0] sat_count
);
  state_t state, state_nxt;
  req_id_t last_id, gnt_id, id_q;
  logic gnt_any, slot_free, accept, add_sat;
  logic [WIDTH-1:0] add_a, add_b, add_sum;
  always_comb begin
    gnt_any    = req0_valid || req1_valid;
    gnt_id     = (req0_valid && req1_valid) ? req_id_t'(~last_id) : req_id_t'(req1_valid);
    slot_free  = (state == EMPTY) || res_ready;
    accept     = !rst && slot_free && gnt_any;
    req0_ready = accept && (gnt_id == REQ0);
    req1_ready = accept && (gnt_id == REQ1);
    add_a      = (gnt_id == REQ1) ? req1_a : req0_a;
    add_b      = (gnt_id == REQ1) ? req1_b : req0_b;
  end
  sat_adder #(.WIDTH(WIDTH)) u_add (.a(add_a), .b(add_b), .sum(add_sum), .sat(add_sat));
  always_ff @(posedge clk)
    state <= rst ? EMPTY : state_nxt;
  always_comb
    state_nxt = (accept || (state == FULL && !res_ready)) ? FULL : EMPTY;
  always_comb begin
    res_valid = (state == FULL);
    res_id    = id_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      res_sum   <= '0;
      id_q      <= REQ0;
      res_sat   <= 1'b0;
      sat_count <= '0;
      last_id   <= REQ1;
    end else if (accept) begin
      res_sum   <= add_sum;
      id_q      <= gnt_id;
      res_sat   <= add_sat;
      last_id   <= gnt_id;
      if (add_sat && sat_count != '1) sat_count <= sat_count + 1'b1;
    end
  end
endmodule
